bcd_addsub_seq: RTL
===================

Name: bcd_addsub_seq

Overview:
- Multi-digit BCD add/subtract sequencer.
- Holds one combinational single-digit BCD add/sub stage and reuses it once per clock, least-significant digit first, chaining the carry between digits.
- Optional second pass turns a negative 10's-complement result into sign-magnitude.
- Start/busy/done handshake toward the issuing controller.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- mode  input  1  0 = add, 1 = subtract; captured at start.
- cin  input  1  carry-in to the LSD; captured at start.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- result  output  4*DIGITS  packed BCD result (magnitude when neg=1).
- cout  output  1  final decimal carry (add), or no-borrow flag (subtract).
- neg  output  1  subtract result was negative; result holds the magnitude.
- err  output  1  an operand digit was > 9 at start.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE. result, cout, neg, err, busy, done = 0. Digit index = 0. Captured operands cleared.
- Reset is honoured in any state; an in-flight operation is abandoned with no done pulse.
- Digit stage:
  - Operand y = b_i (add) or 9 - b_i (subtract).
  - t = a_i + y + c.
  - If t > 9: digit = t + 6 (low 4 bits), carry = 1; else digit = t, carry = 0.
  - c for digit 0 = captured cin; for digit i>0, c = carry out of digit i-1.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - busy=0. start=1 captures a, b, mode, cin.
  - If any nibble of a or b > 9: go to DONE, err=1, result=0, cout=0, neg=0.
  - Otherwise: go to CALC, index=0, err=0, neg=0.
  - start=0: remain in IDLE; outputs hold the previous result.
- CALC (busy=1):
  - Each cycle writes digit[index] into result and registers the carry.
  - After digit DIGITS-1: cout = final carry.
  - If mode=1 and final carry=0: go to FIX, index=0, chain carry-in=1.
  - Otherwise: go to DONE.
  - Duration is exactly DIGITS cycles.
- FIX (busy=1):
  - Each cycle: result digit i = BCD digit of (9 - result_i) + c, using the same correction rule. Carry-in to digit 0 = 1.
  - After DIGITS cycles: neg=1, cout stays 0, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. result, cout, neg, err stay held until the next accepted start.
- Latency from the start edge to the done cycle:
  - DIGITS+1 cycles: add, or subtract with a non-negative result.
  - 2*DIGITS+1 cycles: negative subtract.
  - 1 cycle: err.
- start while busy, or in DONE: ignored, never queued.
- Operand inputs may change after the start edge; only captured copies are used.
- Add overflow: result wraps modulo 10^DIGITS, with cout=1.
- Subtract with cin=0 computes A-B-1.
- A-B=0 gives result 0, cout=1, neg=0 (never "negative zero").
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. DIGITS=4, add a=0x1234, b=0x5678, cin=0. Expect done 5 cycles after the start edge, result=0x6912, cout=0, neg=0, busy high for cycles 1-4.
2. Add a=0x9999, b=0x0001, cin=0. Expect result=0x0000, cout=1, neg=0. Then add a=0x0500, b=0x0499, cin=1. Expect result=0x1000, cout=0.
3. Subtract a=0x5000, b=0x1234, cin=1. Expect result=0x3766, cout=1, neg=0, done at cycle 5. Subtract a=0x0005, b=0x0005, cin=1. Expect result=0x0000, cout=1, neg=0.
4. Subtract a=0x0006, b=0x0009, cin=1. Expect result=0x0003, neg=1, cout=0, done at cycle 9, busy through FIX.
5. Start with a=0x12A4. Expect done the next cycle, err=1, result=0, busy never asserted. Follow with a valid add; err must clear to 0.
6. Pulse start again in cycle 2 of an add: it must be ignored, producing a single done and an unchanged result. Assert rst in cycle 2 of a new op: next cycle all outputs are 0 and no done fires. The following start completes correctly.

Source files
------------

// File: rtl/bcd_addsub_seq_if.sv
// Start/result handshake bundle between an issuing controller and the BCD add/sub sequencer.
interface bcd_addsub_seq_if #(
  parameter int unsigned DIGITS = 4
) ();
  localparam int unsigned W = 4 * DIGITS;

  logic         start;
  logic         mode;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         cout;
  logic         neg;
  logic         err;
  logic         busy;
  logic         done;

  modport master (
    output start, mode, cin, a, b,
    input  result, cout, neg, err, busy, done
  );

  modport slave (
    input  start, mode, cin, a, b,
    output result, cout, neg, err, busy, done
  );
endinterface

// File: rtl/bcd_addsub_seq.sv
// Multi-digit BCD add/subtract: one digit stage reused per clock, LSD first,
// with an optional second pass converting a negative 10's-complement result
// into sign-magnitude.
module bcd_addsub_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_addsub_seq_if.slave    bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            mode_q, mode_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [3:0]      x_c;
  logic [3:0]      y_c;
  logic [4:0]      t_c;
  logic [3:0]      digit_c;
  logic            carry_c;
  logic            last_c;
  logic            bad_c;

  function automatic logic [3:0] get_digit(input logic [W-1:0] v, input logic [IW-1:0] idx);
    logic [3:0] d;
    d = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IW'(i) == idx) d = v[i*4 +: 4];
    end
    return d;
  endfunction

  function automatic logic [W-1:0] put_digit(input logic [W-1:0] v, input logic [IW-1:0] idx,
                                             input logic [3:0] d);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IW'(i) == idx) r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Shared single-digit BCD stage; FIX pass feeds (9 - result digit) with a zero operand.
  always_comb begin
    x_c = '0;
    y_c = '0;
    if (state_q == S_FIX) begin
      x_c = 4'd9 - get_digit(result_q, idx_q);
    end else begin
      x_c = get_digit(a_q, idx_q);
      y_c = mode_q ? (4'd9 - get_digit(b_q, idx_q)) : get_digit(b_q, idx_q);
    end
    t_c = 5'(x_c) + 5'(y_c) + 5'(carry_q);
    if (t_c > 5'd9) begin
      digit_c = 4'(t_c + 5'd6);
      carry_c = 1'b1;
    end else begin
      digit_c = t_c[3:0];
      carry_c = 1'b0;
    end
    last_c = (idx_q == IW'(DIGITS - 1));
    bad_c  = has_bad_digit(bus.a) | has_bad_digit(bus.b);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = bad_c ? S_DONE : S_CALC;
      S_CALC: if (last_c)    state_d = (mode_q && !carry_c) ? S_FIX : S_DONE;
      S_FIX:  if (last_c)    state_d = S_DONE;
      S_DONE:                state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    neg_d    = neg_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          mode_d   = bus.mode;
          carry_d  = bus.cin;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          neg_d    = 1'b0;
          err_d    = bad_c;
        end
      end
      S_CALC: begin
        result_d = put_digit(result_q, idx_q, digit_c);
        carry_d  = carry_c;
        idx_d    = idx_q + IW'(1);
        if (last_c) begin
          idx_d  = '0;
          cout_d = carry_c;
          // Negative subtract: the FIX pass starts with a carry-in of one.
          if (mode_q && !carry_c) carry_d = 1'b1;
        end
      end
      S_FIX: begin
        result_d = put_digit(result_q, idx_q, digit_c);
        carry_d  = carry_c;
        idx_d    = idx_q + IW'(1);
        if (last_c) begin
          idx_d = '0;
          neg_d = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule
